// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader.
// States, word packing size and the image size limit derived from the address width.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    localparam int unsigned BYTES_PER_WORD = 4;

    function automatic logic [31:0] max_words(input int unsigned addr_bits);
        return 32'd1 << addr_bits;
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Host-side byte stream, instruction RAM write port and loader status.
// The loader uses the slave modport; the stream source and RAM use master.
interface instr_loader_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             cpu_hold;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
    );

endinterface

// File: rtl/instr_loader_byte_packer.sv
// Big-endian byte-to-word packer: the first byte of a word ends up in bits [31:24].
// word_valid_o is combinational and coincides with the accepted fourth byte.
module instr_loader_byte_packer
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q;
    logic [23:0] shift_q;

    assign word_valid_o = byte_valid_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word_o       = {shift_q, byte_i};

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (byte_valid_i) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= {shift_q[15:0], byte_i};
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Loads a length-prefixed program image from a byte stream into instruction RAM.
// Define INSTR_LOADER_CHECKSUM_EN to require a 32-bit sum trailer after the data words.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned ROM_ADDR_BITS = 12
) (
    input  logic          clk,
    input  logic          reset,
    instr_loader_if.slave bus
);

    localparam int unsigned AW       = ROM_ADDR_BITS + 1;
    localparam logic [31:0] MaxWords = max_words(ROM_ADDR_BITS);

    state_e           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW-1:0]    len_q, len_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic             in_xfer;
    logic             take;
    logic             pk_clear;
    logic             pk_word_valid;
    logic [31:0]      pk_word;

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [31:0]      sum_q, sum_d;
`endif

    assign in_xfer = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
    assign take    = bus.rx_valid && in_xfer;

    instr_loader_byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (pk_clear),
        .byte_valid_i (take),
        .byte_i       (bus.rx_data),
        .word_valid_o (pk_word_valid),
        .word_o       (pk_word)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pk_clear    = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif

        case (state_q)
            StIdle, StDone, StErr: begin
                if (bus.start) begin
                    state_d = StLen;
                    addr_d  = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end

            StLen: begin
                if (pk_word_valid) begin
                    if (pk_word == 32'd0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        state_d = StCsum;
`else
                        state_d = StDone;
`endif
                    end else if (pk_word > MaxWords) begin
                        state_d = StErr;
                    end else begin
                        len_d   = AW'(pk_word);
                        state_d = StData;
                    end
                end
            end

            StData: begin
                if (pk_word_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = WIDTH'(addr_q);
                    mem_wdata_d = WIDTH'(pk_word);
                    addr_d      = addr_q + AW'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
                    sum_d       = sum_q + pk_word;
`endif
                    if (addr_q == len_q - AW'(1)) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        state_d = StCsum;
`else
                        state_d = StDone;
`endif
                    end
                end
            end

`ifdef INSTR_LOADER_CHECKSUM_EN
            StCsum: begin
                if (pk_word_valid) begin
                    state_d = (pk_word == sum_q) ? StDone : StErr;
                end
            end
`endif

            default: state_d = StIdle;
        endcase

        // Every state entry starts a fresh word in the packer.
        if (state_d != state_q) begin
            pk_clear = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            len_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // The final strobe lands in the first DONE cycle; release the CPU only after it.
    assign bus.rx_ready  = in_xfer;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = in_xfer || mem_we_q;
    assign bus.done      = (state_q == StDone) && !mem_we_q;
    assign bus.error     = (state_q == StErr);
    assign bus.cpu_hold  = !bus.done;

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer side of the instruction memory: fills the processor's instruction store before execution.
- Receives a program image as a byte stream (valid/ready, typically from a UART receiver) and assembles 32-bit words.
- Drives a word-addressed write port into the instruction RAM, the same address space the PC indexes.
- Holds the CPU in reset while loading, and releases it on success.

Parameters:
- WIDTH, 32, instruction/data word width; the byte packer assumes 32.
- ROM_ADDR_BITS, 12, instruction memory depth as log2 of words; maximum image is 2**ROM_ADDR_BITS words.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- rx_data  input  8  incoming image byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction RAM write strobe, one cycle per word.
- mem_addr  output  WIDTH  word address; upper bits above ROM_ADDR_BITS are always 0.
- mem_wdata  output  WIDTH  assembled instruction word.
- cpu_hold  output  1  holds the processor in reset.
- busy  output  1  load in progress.
- done  output  1  level; image loaded successfully.
- error  output  1  level; load failed.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, busy=0, done=0, error=0; state=IDLE.
- Reset mid-load: the next edge returns everything to reset values. No further write is issued.
- Byte transfer: a byte is taken when rx_valid && rx_ready on a clk edge. rx_ready=1 only in LEN, DATA and CSUM.
- Byte order: big-endian. The first byte of each word lands in bits [31:24].
- IDLE:
  - cpu_hold=1.
  - On start: clear the byte counter, address counter, done and error; go to LEN.
- LEN:
  - Accept 4 bytes to form N, the image length in words.
  - N==0: go to DONE.
  - N > 2**ROM_ADDR_BITS: go to ERR.
  - Otherwise: go to DATA.
- DATA:
  - Accept bytes. On the 4th byte of a word, register mem_wdata=word and mem_addr=word index, and set mem_we=1 for exactly the following cycle.
  - The word index starts at 0 and increments after each write.
  - rx_ready stays 1 while mem_we is high; a back-to-back byte every cycle is legal.
  - After word N-1 is accepted, go to DONE (or CSUM when CHECKSUM_EN is defined).
  - The final write strobe still occurs after the transition.
- DONE:
  - done=1, busy=0, cpu_hold=0 starting the cycle after the final mem_we.
  - Remains until reset or start.
- ERR:
  - error=1, cpu_hold=1, busy=0, rx_ready=0; further bytes are ignored.
  - Cleared only by start or reset.
- busy=1 in LEN, DATA and CSUM.
- cpu_hold=1 in every state except DONE.
- start while busy is ignored.
- Address counter is ROM_ADDR_BITS+1 bits wide. Because N is range-checked, it never wraps.
- mem_we never asserts outside the cycle following a completed data word.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- Defined:
  - A running 32-bit sum, mod 2^32, of all data words is kept.
  - After the last data word, state CSUM accepts a 4-byte big-endian trailer.
  - Match: go to DONE. Mismatch: go to ERR.
  - With N==0, CSUM is still entered and the expected trailer is 0.
- Undefined:
  - No CSUM state and no trailer; DATA goes directly to DONE.

Decomposition:
- Shared package instr_loader_pkg holds:
  - state encoding constants: IDLE, LEN, DATA, CSUM, DONE, ERR;
  - BYTES_PER_WORD=4;
  - a max-words function of ROM_ADDR_BITS.
- One sub-module, byte_packer: shifts in bytes MSB-first, counts 0..3, and pulses word_valid with the 32-bit word.
  - Used for the length header, the data words and the checksum trailer.
  - Cleared on state entry.

Test Plan:
- Load N=3 with words 0x11223344, 0xDEADBEEF, 0x00000001, bytes every cycle -> mem_we pulses 3 times, addr 0,1,2 with matching data; done=1 and cpu_hold=0 one cycle after the third strobe.
- Same image with rx_valid toggling 1-0-1 -> identical writes; rx_ready behaves the same; no extra strobes.
- Header N=0x00001001 with ROM_ADDR_BITS=12 -> ERR: error=1, cpu_hold=1, no mem_we; a subsequent start plus a valid N=1 image loads correctly.
- reset asserted after 5 data bytes of N=2 -> next cycle all outputs at reset values; exactly 1 write occurred before reset.
- start pulsed mid-DATA -> ignored; the load completes normally.
- INSTR_LOADER_CHECKSUM_EN, N=2 with 0x00000005 and 0xFFFFFFFE: trailer 0x00000003 -> done=1; trailer 0x00000004 -> error=1, cpu_hold=1.
